row_multiplier: RTL and testbench
=================================

# row_multiplier

Dot-product engine for one output row of a 784-input (28×28 pixel) fully connected layer with 10 output rows. On `begin_mult` it streams all 784 pixel/weight pairs from two dual-ported memories, two pairs per cycle, and accumulates their unsigned products into a saturating 16-bit row result with an overflow flag. It sits between the pixel/weight memories and the layer controller, which issues one `begin_mult` per row.

## Interface
Parameters (fixed, no overrides):
- NUM_PIXELS, 784, pixels per image
- NUM_ROWS, 10, output rows; valid `row_select` values are 0–9

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- row_select  in  4  output row to compute; sampled only at start
- begin_mult  in  1  start pulse; sampled at rising edge while IDLE
- pixel_value_1  in  8  unsigned pixel at pixel_address_1, valid one cycle after the address
- pixel_value_2  in  8  unsigned pixel at pixel_address_2, same timing
- weight_value_1  in  16  unsigned weight at weight_address_1, same timing
- weight_value_2  in  16  unsigned weight at weight_address_2, same timing
- pixel_address_1  out  10  even pixel index 2k
- pixel_address_2  out  10  odd pixel index 2k+1
- weight_address_1  out  13  row*784 + 2k
- weight_address_2  out  13  row*784 + 2k+1
- done_row  out  1  one-cycle pulse; result is final
- row_result  out  16  saturating sum of pixel×weight over 784 pixels
- overflow  out  1  set when the true sum exceeded 65535

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: addresses are 0. When `begin_mult`=1, the block:
  - latches `row_select`,
  - clears the accumulator and `overflow`,
  - sets k=0 and goes to RUN.
- Out-of-range start: if the latched `row_select` is greater than 9, the block goes straight to DONE with `row_result`=0 and `overflow`=0.
- RUN: the block drives the addresses for pair k, then increments k each cycle. When k=391 it goes to DRAIN.
- Weight base: row*784 is latched at start and held in a register. Weight addresses are base+2k and base+2k+1. No multiplier is used; the base is built by repeated add or an equivalent.
- Accumulate: in every cycle after a RUN cycle (the later RUN cycles plus DRAIN), the block adds p1×w1 + p2×w2 to the accumulator.
  - Each product is 24-bit unsigned.
  - The block keeps at least a 26-bit internal sum, or saturates at every step.
- Saturation: when the running sum exceeds 65535, `overflow` is set sticky and the accumulator clamps at 16'hFFFF.
- DRAIN: accumulates the last pair, then goes to DONE.
- DONE: `done_row`=1 for exactly one cycle, then the block returns to IDLE.
- Held outputs: `row_result` and `overflow` hold their final values until the next accepted `begin_mult`.
- During RUN, DRAIN and DONE, `begin_mult` is ignored.
- Row result: equals the accumulator, clamped to 16'hFFFF.

## Timing
- Reset values: state IDLE, all addresses 0, `done_row` 0, `row_result` 0, `overflow` 0, k 0.
- Edge 0 is the edge where `begin_mult` is sampled. Then:
  - RUN spans cycles 1–392,
  - DRAIN is cycle 393,
  - `done_row` is high in cycle 394 (visible after edge 393).
- Latency: 393 edges from start to `done_row`.
- Memory data for the address driven in cycle c must be stable throughout cycle c+1.
- Reset mid-operation: the block returns to IDLE immediately and all outputs go to their reset values.
- Out-of-range row: `done_row` pulses in cycle 1.

## Structure
- Package `row_multiplier_pkg`:
  - constants NUM_PIXELS=784, NUM_PAIRS=392, NUM_ROWS=10, PIX_W=8, WGT_W=16, RES_W=16, PADDR_W=10, WADDR_W=13,
  - state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, `pair_mac`: a two-product saturating accumulator with inputs clear, enable, p1, w1, p2, w2 and outputs sum and overflow.
- The top level holds the FSM, the pair counter and the address generation.

## Test plan
- All pixels 1, all weights 1, row 0 → `done_row` after 393 edges, `row_result`=784, `overflow`=0.
- Pixels 1, weight_value_1=1, weight_value_2=0, row 1 → `row_result`=392, `overflow`=0. Weight addresses run 784..1567.
- Pixels 1, weight_value_1=168, weight_value_2=0 → true sum 65856. Required: `overflow`=1, `row_result`=16'hFFFF.
- Pixels 255, weights 0 → `row_result`=0, `overflow`=0. A second `begin_mult` after that clears any previous overflow.
- Row 9: last cycle of RUN shows `pixel_address_1`=782, `pixel_address_2`=783, `weight_address_1`=7838, `weight_address_2`=7839. `begin_mult` pulses during RUN are ignored.
- Assert `rst` at cycle 200 of RUN → all outputs 0 and state IDLE. A new start then produces a correct full result.

Source files
------------

// File: rtl/row_multiplier_pkg.sv
// rtl/row_multiplier_pkg.sv - shared constants, state type and row base helper
package row_multiplier_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int NUM_PAIRS  = 392;
  localparam int NUM_ROWS   = 10;
  localparam int PIX_W      = 8;
  localparam int WGT_W      = 16;
  localparam int RES_W      = 16;
  localparam int PADDR_W    = 10;
  localparam int WADDR_W    = 13;
  localparam int CNT_W      = 9;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // row*784 as shift-add: 784 = 512 + 256 + 16
  function automatic logic [WADDR_W-1:0] row_base(input logic [3:0] row);
    logic [WADDR_W-1:0] r;
    r = WADDR_W'(row);
    return (r << 9) + (r << 8) + (r << 4);
  endfunction

endpackage

// File: rtl/row_multiplier_pair_mac.sv
// rtl/row_multiplier_pair_mac.sv - two-product accumulator saturating at each step
module pair_mac
  import row_multiplier_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [PIX_W-1:0] p1,
  input  logic [WGT_W-1:0] w1,
  input  logic [PIX_W-1:0] p2,
  input  logic [WGT_W-1:0] w2,
  output logic [RES_W-1:0] sum,
  output logic             overflow
);

  localparam int PROD_W = PIX_W + WGT_W;
  localparam int ACC_W  = PROD_W + 2;

  logic [RES_W-1:0]  sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic [PROD_W-1:0] prod1, prod2;
  logic [ACC_W-1:0]  total;

  always_comb begin
    prod1 = PROD_W'(p1) * PROD_W'(w1);
    prod2 = PROD_W'(p2) * PROD_W'(w2);
    total = ACC_W'(sum_q) + ACC_W'(prod1) + ACC_W'(prod2);
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (clear) begin
      sum_d = '0;
      ovf_d = 1'b0;
    end else if (enable) begin
      if (total[ACC_W-1:RES_W] != '0) begin
        sum_d = '1;
        ovf_d = 1'b1;
      end else begin
        sum_d = total[RES_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/row_multiplier.sv
// rtl/row_multiplier.sv - one FC-layer row dot product, two pixel/weight pairs per cycle
module row_multiplier
  import row_multiplier_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         row_select,
  input  logic               begin_mult,
  input  logic [PIX_W-1:0]   pixel_value_1,
  input  logic [PIX_W-1:0]   pixel_value_2,
  input  logic [WGT_W-1:0]   weight_value_1,
  input  logic [WGT_W-1:0]   weight_value_2,
  output logic [PADDR_W-1:0] pixel_address_1,
  output logic [PADDR_W-1:0] pixel_address_2,
  output logic [WADDR_W-1:0] weight_address_1,
  output logic [WADDR_W-1:0] weight_address_2,
  output logic               done_row,
  output logic [RES_W-1:0]   row_result,
  output logic               overflow
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [WADDR_W-1:0] base_q, base_d;
  logic               mac_clear, mac_en, running;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    base_d    = base_q;
    mac_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (begin_mult) begin
          mac_clear = 1'b1;
          k_d       = '0;
          if (row_select > 4'(NUM_ROWS - 1)) begin
            state_d = DONE;
          end else begin
            base_d  = row_base(row_select);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (k_q == CNT_W'(NUM_PAIRS - 1)) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
    end
  end

  // Memory returns data one cycle after the address, so the MAC trails RUN by a cycle
  assign running = (state_q == RUN);
  assign mac_en  = (running && k_q != '0) || (state_q == DRAIN);

  assign pixel_address_1  = running ? {k_q, 1'b0} : '0;
  assign pixel_address_2  = running ? {k_q, 1'b1} : '0;
  assign weight_address_1 = running ? base_q + WADDR_W'({k_q, 1'b0}) : '0;
  assign weight_address_2 = running ? base_q + WADDR_W'({k_q, 1'b1}) : '0;
  assign done_row         = (state_q == DONE);

  pair_mac u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (mac_clear),
    .enable   (mac_en),
    .p1       (pixel_value_1),
    .w1       (weight_value_1),
    .p2       (pixel_value_2),
    .w2       (weight_value_2),
    .sum      (row_result),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_row_multiplier.sv
// tb/tb_row_multiplier.sv - directed self-checking bench for row_multiplier
module tb_row_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_select;
  logic        begin_mult;
  logic [7:0]  pixel_value_1, pixel_value_2;
  logic [15:0] weight_value_1, weight_value_2;
  logic [9:0]  pixel_address_1, pixel_address_2;
  logic [12:0] weight_address_1, weight_address_2;
  logic        done_row;
  logic [15:0] row_result;
  logic        overflow;

  logic [7:0]  pix_mem [0:1023];
  logic [15:0] wgt_mem [0:8191];

  int errors = 0;
  int checks = 0;

  int          r_done_cyc;
  logic [15:0] r_res, r_res_after;
  logic        r_ovf, r_done_after;
  logic [12:0] r_wa1_first, r_wa1_last, r_wa2_last;
  logic [9:0]  r_pa1_last, r_pa2_last;

  always #5 clk = ~clk;

  row_multiplier dut (
    .clk              (clk),
    .rst              (rst),
    .row_select       (row_select),
    .begin_mult       (begin_mult),
    .pixel_value_1    (pixel_value_1),
    .pixel_value_2    (pixel_value_2),
    .weight_value_1   (weight_value_1),
    .weight_value_2   (weight_value_2),
    .pixel_address_1  (pixel_address_1),
    .pixel_address_2  (pixel_address_2),
    .weight_address_1 (weight_address_1),
    .weight_address_2 (weight_address_2),
    .done_row         (done_row),
    .row_result       (row_result),
    .overflow         (overflow)
  );

  // Synchronous-read memories: data for an address appears in the following cycle
  always @(posedge clk) begin
    pixel_value_1  <= pix_mem[pixel_address_1];
    pixel_value_2  <= pix_mem[pixel_address_2];
    weight_value_1 <= wgt_mem[weight_address_1];
    weight_value_2 <= wgt_mem[weight_address_2];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int pv, input int w_even, input int w_odd);
    for (int i = 0; i < 1024; i++) pix_mem[i] = 8'(pv);
    for (int i = 0; i < 8192; i++) wgt_mem[i] = (i % 2 == 0) ? 16'(w_even) : 16'(w_odd);
  endtask

  task automatic run(input logic [3:0] row, input int pulse_at, input int rst_at);
    r_done_cyc = -1;
    @(negedge clk);
    row_select = row;
    begin_mult = 1'b1;
    @(posedge clk);
    #1;
    begin_mult = 1'b0;
    row_select = 4'd0;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(negedge clk);
      begin_mult = (cyc == pulse_at);
      if (cyc == 1) r_wa1_first = weight_address_1;
      if (cyc == 392) begin
        r_pa1_last = pixel_address_1;
        r_pa2_last = pixel_address_2;
        r_wa1_last = weight_address_1;
        r_wa2_last = weight_address_2;
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        r_done_cyc = -2;
        break;
      end
      if (done_row) begin
        r_done_cyc = cyc;
        r_res = row_result;
        r_ovf = overflow;
        break;
      end
    end
    begin_mult = 1'b0;
    if (r_done_cyc > 0) begin
      @(negedge clk);
      r_done_after = done_row;
      r_res_after  = row_result;
    end
  endtask

  initial begin
    rst = 1'b1;
    begin_mult = 1'b0;
    row_select = 4'd0;
    fill(1, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pa1", 32'(pixel_address_1), 0);
    check("reset_wa2", 32'(weight_address_2), 0);
    check("reset_done", 32'(done_row), 0);
    check("reset_result", 32'(row_result), 0);
    check("reset_ovf", 32'(overflow), 0);
    rst = 1'b0;

    // all ones, row 0
    run(4'd0, 0, 0);
    check("t1_done_cycle", 32'(r_done_cyc), 394);
    check("t1_result", 32'(r_res), 784);
    check("t1_ovf", 32'(r_ovf), 0);
    check("t1_wa1_first", 32'(r_wa1_first), 0);
    check("t1_done_pulse", 32'(r_done_after), 0);
    check("t1_result_hold", 32'(r_res_after), 784);
    check("t1_idle_addr", 32'(weight_address_1), 0);

    // odd weights zero, row 1
    fill(1, 1, 0);
    run(4'd1, 0, 0);
    check("t2_done_cycle", 32'(r_done_cyc), 394);
    check("t2_result", 32'(r_res), 392);
    check("t2_ovf", 32'(r_ovf), 0);
    check("t2_wa1_first", 32'(r_wa1_first), 784);
    check("t2_wa2_last", 32'(r_wa2_last), 1567);

    // 392 * 168 = 65856 saturates
    fill(1, 168, 0);
    run(4'd2, 0, 0);
    check("t3_result", 32'(r_res), 16'hFFFF);
    check("t3_ovf", 32'(r_ovf), 1);
    check("t3_wa1_first", 32'(r_wa1_first), 1568);

    // zero weights, overflow must clear
    fill(255, 0, 0);
    run(4'd3, 0, 0);
    check("t4_result", 32'(r_res), 0);
    check("t4_ovf", 32'(r_ovf), 0);

    // row 9 with stray begin_mult during RUN
    fill(1, 2, 2);
    run(4'd9, 100, 0);
    check("t5_done_cycle", 32'(r_done_cyc), 394);
    check("t5_result", 32'(r_res), 1568);
    check("t5_pa1_last", 32'(r_pa1_last), 782);
    check("t5_pa2_last", 32'(r_pa2_last), 783);
    check("t5_wa1_last", 32'(r_wa1_last), 7838);
    check("t5_wa2_last", 32'(r_wa2_last), 7839);
    check("t5_no_restart", 32'(done_row), 0);

    // out-of-range row
    run(4'd12, 0, 0);
    check("t6_done_cycle", 32'(r_done_cyc), 1);
    check("t6_result", 32'(r_res), 0);
    check("t6_ovf", 32'(r_ovf), 0);

    // reset in the middle of RUN, then a clean run
    fill(1, 1, 1);
    run(4'd0, 0, 200);
    #1;
    check("t7_rst_flag", 32'(r_done_cyc), 32'hFFFF_FFFE);
    check("t7_rst_pa1", 32'(pixel_address_1), 0);
    check("t7_rst_wa1", 32'(weight_address_1), 0);
    check("t7_rst_done", 32'(done_row), 0);
    check("t7_rst_result", 32'(row_result), 0);
    check("t7_rst_ovf", 32'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    run(4'd0, 0, 0);
    check("t7_done_cycle", 32'(r_done_cyc), 394);
    check("t7_result", 32'(r_res), 784);
    check("t7_ovf", 32'(r_ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
